pipe_perf_counters: RTL

Synthesizable event-counter block for the pipelined CPU. It replaces ad-hoc stall and flush counting in simulation with hardware counters that run in silicon and in simulation alike. It counts NUM_CH pipeline events over a bounded run window, reports sticky overflow per channel, and exposes an atomic snapshot bank through a registered read port. It sits beside the CPU top, with its event inputs driven from the hazard unit, the branch-resolve logic and the writeback stage.

---
 rtl/perf_pkg.sv | 23 ++
 rtl/perf_counter_cell.sv | 53 +++++
 rtl/pipe_perf_counters.sv | 125 ++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the pipeline performance-counter block.
// Holds the run-state enum, the CPU event channel assignments, and a helper
// that sizes the shadow-select port (NUM_CH channels plus one cycle shadow).
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_state_e;

    // Event channel wiring on the CPU side
    localparam int CH_STALL  = 0;  // hazard stall, qualified by no branch in ID
    localparam int CH_FLUSH  = 1;  // branch flush
    localparam int CH_RETIRE = 2;  // writeback with RegWrite
    localparam int CH_MEM    = 3;  // data-memory access

    // Select must address every channel shadow plus the cycle shadow.
    function automatic int sel_width(input int num_ch);
        return $clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter with increment enable, saturate-or-wrap behaviour and a
// sticky overflow flag.
//   clk_i  : clock
//   rst_i  : asynchronous active-low reset
//   clr_i  : synchronous clear of count and overflow flag (wins over inc_i)
//   inc_i  : add one this edge
//   cnt_o  : current count
//   ovf_o  : set when an increment would pass all-ones; held until clear/reset
module perf_counter_cell #(
    parameter int CNT_W = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = SAT ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pipe_perf_counters.sv
// Pipeline event counters over a bounded run window with an atomic snapshot
// bank and a registered read port.
//   clk_i, rst_i   : clock, asynchronous active-low reset
//   start_i        : IDLE -> RUN
//   clear_i        : zero counters, flags and shadows; back to IDLE
//   freeze_i       : hold event counters in RUN (cycle counter keeps going)
//   event_i        : per-channel event strobes
//   snap_i         : copy live counters (pre-increment values) into shadows
//   rd_sel_i       : shadow select; NUM_CH selects the cycle shadow
//   rd_data_o      : registered shadow read, 0 for out-of-range selects
//   snap_valid_o   : one-cycle pulse after a snapshot
//   cycle_o        : live run-cycle count
//   ovf_o          : sticky per-channel overflow
//   done_o         : high in DONE
module pipe_perf_counters
    import perf_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64,
    parameter bit SAT        = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           clear_i,
    input  logic                           freeze_i,
    input  logic [NUM_CH-1:0]              event_i,
    input  logic                           snap_i,
    input  logic [sel_width(NUM_CH)-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]               rd_data_o,
    output logic                           snap_valid_o,
    output logic [CNT_W-1:0]               cycle_o,
    output logic [NUM_CH-1:0]              ovf_o,
    output logic                           done_o
);

    localparam int               SEL_W    = sel_width(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH);
    // Cycle count just before the window closes; unused when MAX_CYCLES = 0.
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

    perf_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_all  [0:NUM_CH];  // index NUM_CH is the cycle counter
    logic [CNT_W-1:0] shadow_q [0:NUM_CH];
    logic [CNT_W-1:0] rd_data_q;
    logic             snap_valid_q;
    logic             run;
    logic             cyc_ovf_unused;

    assign run = (state_q == RUN);

    // ---------------- run-state machine ----------------
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = RUN;
                RUN:     if (MAX_CYCLES != 0 && cycle_o == LAST_CYC) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- counters ----------------
    generate
        for (genvar gi = 0; gi <= NUM_CH; gi++) begin : g_cell
            if (gi < NUM_CH) begin : g_evt
                perf_counter_cell #(.CNT_W(CNT_W), .SAT(SAT)) u_cell (
                    .clk_i (clk_i),
                    .rst_i (rst_i),
                    .clr_i (clear_i),
                    .inc_i (run && !freeze_i && event_i[gi]),
                    .cnt_o (cnt_all[gi]),
                    .ovf_o (ovf_o[gi])
                );
            end else begin : g_cyc
                perf_counter_cell #(.CNT_W(CNT_W), .SAT(SAT)) u_cell (
                    .clk_i (clk_i),
                    .rst_i (rst_i),
                    .clr_i (clear_i),
                    .inc_i (run),
                    .cnt_o (cnt_all[gi]),
                    .ovf_o (cyc_ovf_unused)
                );
            end
        end
    endgenerate

    assign cycle_o = cnt_all[NUM_CH];

    // ---------------- snapshot bank and read port ----------------
    // Shadows sample the counter outputs, i.e. the values before this edge's
    // increments, so every channel lands in the bank from the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i <= NUM_CH; i++) shadow_q[i] <= '0;
            snap_valid_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            if (clear_i) begin
                for (int i = 0; i <= NUM_CH; i++) shadow_q[i] <= '0;
            end else if (snap_i) begin
                for (int i = 0; i <= NUM_CH; i++) shadow_q[i] <= cnt_all[i];
            end
            snap_valid_q <= snap_i && !clear_i;
            // Reads see the bank as it was before this edge's capture.
            if (rd_sel_i <= LAST_SEL) rd_data_q <= shadow_q[rd_sel_i];
            else                      rd_data_q <= '0;
        end
    end

    assign rd_data_o    = rd_data_q;
    assign snap_valid_o = snap_valid_q;
    assign done_o       = (state_q == DONE);

endmodule
